uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, 8N1, LSB first, fixed baud set by `CYCLES_PER_BIT`. It is the receive-side counterpart of the project's UART transmitter and uses the same bit timing and parameter, so the two can be looped back directly. It synchronises the asynchronous RX pin, validates the start bit at mid-bit, samples each data bit at its centre and checks the stop bit. Each result is reported as a one-cycle pulse: a data-valid pulse for a good byte, a framing-error pulse for a bad stop bit.

## Interface
- `CYCLES_PER_BIT`, 217: `i_clk` cycles per bit (25 MHz / 115200). Legal range ≥ 4.
- `i_clk` input 1: system clock; all logic is on its rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_rx_serial` input 1: asynchronous serial line; idles high.
- `o_rx_byte` output 8: last good byte; holds its value until the next good frame.
- `o_rx_dv` output 1: one-cycle pulse when `o_rx_byte` has just been updated.
- `o_rx_framing_err` output 1: one-cycle pulse when the stop bit sampled low.
- `o_rx_active` output 1: high while a frame is in progress.

## Operation
- Input synchroniser: two flops, both reset to 1. All FSM logic sees only `rx_s`, the second flop.
- Widths: `count` is $clog2(CYCLES_PER_BIT) bits; `bit_count` is 3 bits.
- Half-bit point: H = (CYCLES_PER_BIT-1)/2, integer division.
- IDLE:
  - `rx_s`==0 → START, `count`<=0.
- START:
  - `count`==H and `rx_s`==0 → DATA, `count`<=0, `bit_count`<=0.
  - `count`==H and `rx_s`==1 → IDLE. This is a glitch; no output is produced.
  - Otherwise `count`++.
- DATA:
  - `count`==CYCLES_PER_BIT-1 → `count`<=0, `shift`<={`rx_s`, `shift`[7:1]}.
  - On that sample, if `bit_count`==7 → STOP; else `bit_count`++.
  - Otherwise `count`++.
- STOP, at `count`==CYCLES_PER_BIT-1:
  - `rx_s`==1 → `o_rx_byte`<=`shift`, `o_rx_dv`<=1, → IDLE.
  - `rx_s`==0 → `o_rx_framing_err`<=1, `o_rx_byte` unchanged, → BREAK_WAIT.
  - Otherwise `count`++.
- BREAK_WAIT:
  - Stay until `rx_s`==1, then → IDLE. A held-low line (break) therefore gives exactly one error and is never taken as a new start bit.
- Pulses: `o_rx_dv` and `o_rx_framing_err` are registered and cleared on every cycle they are not being set. They are never high together.
- `o_rx_active` = state ∈ {START, DATA, STOP}. It is a combinational decode of the registered state.
- Unused state encodings → IDLE on the next edge.
- Reset values:
  - State IDLE.
  - `o_rx_byte`=0x00, `o_rx_dv`=0, `o_rx_framing_err`=0, `o_rx_active`=0.
  - Synchroniser = 1, `count`=0, `bit_count`=0.
- Reset mid-frame aborts the frame: no dv, no error. Reception restarts only on a falling edge seen after reset.

## Timing
- Let t0 = the `i_clk` edge at which `i_rx_serial` is first sampled low.
- Enter START at edge t0+2. `o_rx_active` is high in the following cycle.
- Start-bit check at t0+3+H; DATA is entered at that edge.
- Data bit k (k=0..7) is sampled at edge S+(k+1)·CYCLES_PER_BIT, where S = t0+3+H.
- Stop bit is sampled at edge S+9·CYCLES_PER_BIT.
  - At that edge `o_rx_dv` (or `o_rx_framing_err`) rises and `o_rx_active` falls.
  - The pulse lasts exactly one cycle.
- Example: CYCLES_PER_BIT=8 gives H=3, so `o_rx_dv` is high in the cycle after edge t0+78.
- The receiver re-arms in IDLE about half a bit into the stop bit. Back-to-back frames therefore work with a transmitter stop bit as short as CYCLES_PER_BIT-1 cycles.
- Glitch rejection: a low pulse shorter than about H+1 cycles (after synchronisation) is ignored.

## Test plan
- CYCLES_PER_BIT=8; send frame 0xA5 with an ideal 8-cycle bit period → single `o_rx_dv` pulse at t0+78, `o_rx_byte`=0xA5, `o_rx_framing_err` never high.
- Loop back from the UART transmitter with the same parameter; send 0x00 then 0xFF back-to-back, each with a 7-cycle stop bit → two dv pulses with bytes 0x00 then 0xFF, no errors.
- Drive `i_rx_serial` low for 2 cycles, then high → `o_rx_active` high for at most H+1 cycles, then IDLE; no dv, no error.
- Send 0x3C with the stop bit low, then hold the line low for 20 bit times → exactly one `o_rx_framing_err` pulse, `o_rx_byte` still at its previous value, no dv. After the line returns high, a following 0x3C frame is received correctly.
- Assert `i_rst` for 1 cycle during data bit 4 → all outputs return to their reset values on the next edge. The remainder of the frame produces no dv and no error, and a subsequent frame 0x81 is received correctly.
- CYCLES_PER_BIT=217, 0x5A with the bit period skewed +/-3 % → `o_rx_byte`=0x5A, dv pulse, no error.

Source files
------------

// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver_if
// Brief    : Serial line and byte-result signals of the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_receiver_if;
    logic       i_rx_serial;
    logic [7:0] o_rx_byte;
    logic       o_rx_dv;
    logic       o_rx_framing_err;
    logic       o_rx_active;

    modport slave (
        input  i_rx_serial,
        output o_rx_byte,
        output o_rx_dv,
        output o_rx_framing_err,
        output o_rx_active
    );

    modport master (
        output i_rx_serial,
        input  o_rx_byte,
        input  o_rx_dv,
        input  o_rx_framing_err,
        input  o_rx_active
    );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 8N1 UART receiver, LSB first, mid-bit sampling, framing check.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CYCLES_PER_BIT = 217
) (
    input wire              i_clk,
    input wire              i_rst,
    uart_receiver_if.slave  bus
);

    localparam int                 c_CNT_W   = $clog2(CYCLES_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF    = c_CNT_W'((CYCLES_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(CYCLES_PER_BIT - 1);
    localparam int                 c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [c_CNT_W-1:0]   r_count;
    logic [2:0]           r_bit_count;
    logic [7:0]           r_shift;
    logic [7:0]           r_rx_byte;
    logic                 r_rx_dv;
    logic                 r_rx_framing_err;

    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [2:0]           w_bit_count_nxt;
    logic [7:0]           w_shift_nxt;
    logic [7:0]           w_rx_byte_nxt;
    logic                 w_rx_dv_nxt;
    logic                 w_rx_framing_err_nxt;
    logic                 w_rx_s;

    assign w_rx_s = r_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync           <= 2'b11;
            r_state          <= S_IDLE;
            r_count          <= '0;
            r_bit_count      <= '0;
            r_shift          <= '0;
            r_rx_byte        <= '0;
            r_rx_dv          <= 1'b0;
            r_rx_framing_err <= 1'b0;
        end else begin
            r_sync           <= {r_sync[0], bus.i_rx_serial};
            r_state          <= w_state_nxt;
            r_count          <= w_count_nxt;
            r_bit_count      <= w_bit_count_nxt;
            r_shift          <= w_shift_nxt;
            r_rx_byte        <= w_rx_byte_nxt;
            r_rx_dv          <= w_rx_dv_nxt;
            r_rx_framing_err <= w_rx_framing_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_count_nxt          = r_count;
        w_bit_count_nxt      = r_bit_count;
        w_shift_nxt          = r_shift;
        w_rx_byte_nxt        = r_rx_byte;
        w_rx_dv_nxt          = 1'b0;
        w_rx_framing_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_count_nxt = '0;
                end
            end
            S_START: begin
                // A start bit still low at its centre is genuine; otherwise it was a glitch
                if (r_count == c_HALF) begin
                    w_count_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt     = S_DATA;
                        w_bit_count_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_count_nxt = r_count + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_count == c_LAST) begin
                    w_count_nxt = '0;
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    if (r_bit_count == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_count_nxt = r_bit_count + 3'd1;
                    end
                end else begin
                    w_count_nxt = r_count + c_CNT_W'(1);
                end
            end
            S_STOP: begin
                if (r_count == c_LAST) begin
                    w_count_nxt = '0;
                    if (w_rx_s) begin
                        w_rx_byte_nxt = r_shift;
                        w_rx_dv_nxt   = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_rx_framing_err_nxt = 1'b1;
                        w_state_nxt          = S_BREAK;
                    end
                end else begin
                    w_count_nxt = r_count + c_CNT_W'(1);
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.o_rx_byte        = r_rx_byte;
    assign bus.o_rx_dv          = r_rx_dv;
    assign bus.o_rx_framing_err = r_rx_framing_err;
    assign bus.o_rx_active      = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Drives two receivers (8 and 217 cycles/bit) against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int c_M_IDLE  = 0;
    localparam int c_M_FRAME = 1;
    localparam int c_M_BREAK = 2;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    uart_receiver_if if8();
    uart_receiver_if if217();

    uart_receiver #(.CYCLES_PER_BIT(8)) dut8 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (if8.slave)
    );

    uart_receiver #(.CYCLES_PER_BIT(217)) dut217 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (if217.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: frame position is derived from the absolute edge of the first low sample
    int         m_mode [2] = '{c_M_IDLE, c_M_IDLE};
    int         m_t0   [2];
    logic [7:0] m_data [2];
    bit         line_d1[2] = '{1'b1, 1'b1};
    bit         line_d2[2] = '{1'b1, 1'b1};
    bit         rst_d1 = 1'b1;
    bit         rst_d2 = 1'b1;
    logic [7:0] e_byte [2] = '{8'h00, 8'h00};
    bit         e_dv   [2] = '{1'b0, 1'b0};
    bit         e_err  [2] = '{1'b0, 1'b0};
    bit         e_act  [2] = '{1'b0, 1'b0};

    int dv_cnt [2] = '{0, 0};
    int err_cnt[2] = '{0, 0};
    int act_cnt[2] = '{0, 0};
    int last_dv_cyc[2] = '{0, 0};

    function automatic int cpb_of(input int d);
        return (d == 0) ? 8 : 217;
    endfunction

    always @(posedge i_clk) begin
        bit rx_now[2];
        bit seen;
        int c, base, rel, k;
        rx_now[0] = if8.i_rx_serial;
        rx_now[1] = if217.i_rx_serial;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            c    = cpb_of(d);
            base = 3 + (c - 1) / 2;
            // The receiver acts on the line as it was two edges ago, forced high just after reset
            seen = (rst_d1 || rst_d2) ? 1'b1 : line_d2[d];
            e_dv[d]  = 1'b0;
            e_err[d] = 1'b0;
            if (i_rst) begin
                m_mode[d] = c_M_IDLE;
                e_byte[d] = 8'h00;
            end else begin
                case (m_mode[d])
                    c_M_IDLE: begin
                        if (!seen) begin
                            m_mode[d] = c_M_FRAME;
                            m_t0[d]   = cyc - 2;
                        end
                    end
                    c_M_FRAME: begin
                        rel = cyc - m_t0[d];
                        if (rel == base) begin
                            if (seen) m_mode[d] = c_M_IDLE;
                        end else if (rel > base && ((rel - base) % c) == 0) begin
                            k = (rel - base) / c - 1;
                            if (k < 8) begin
                                m_data[d][k] = seen;
                            end else if (seen) begin
                                e_byte[d] = m_data[d];
                                e_dv[d]   = 1'b1;
                                m_mode[d] = c_M_IDLE;
                            end else begin
                                e_err[d]  = 1'b1;
                                m_mode[d] = c_M_BREAK;
                            end
                        end
                    end
                    default: begin
                        if (seen) m_mode[d] = c_M_IDLE;
                    end
                endcase
            end
            e_act[d]   = (m_mode[d] == c_M_FRAME);
            line_d2[d] = line_d1[d];
            line_d1[d] = rx_now[d];
        end
        rst_d2 = rst_d1;
        rst_d1 = i_rst;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_dut(input int d, input logic [7:0] b, input logic dv,
                           input logic err, input logic act);
        check($sformatf("dut%0d_byte", d), 32'(b),   32'(e_byte[d]));
        check($sformatf("dut%0d_dv", d),   32'(dv),  32'(e_dv[d]));
        check($sformatf("dut%0d_err", d),  32'(err), 32'(e_err[d]));
        check($sformatf("dut%0d_act", d),  32'(act), 32'(e_act[d]));
        if (dv === 1'b1) begin
            dv_cnt[d]++;
            last_dv_cyc[d] = cyc;
        end
        if (err === 1'b1) err_cnt[d]++;
        if (act === 1'b1) act_cnt[d]++;
    endtask

    always @(negedge i_clk) begin
        cmp_dut(0, if8.o_rx_byte, if8.o_rx_dv, if8.o_rx_framing_err, if8.o_rx_active);
        cmp_dut(1, if217.o_rx_byte, if217.o_rx_dv, if217.o_rx_framing_err, if217.o_rx_active);
    end

    task automatic drive(input int d, input bit v);
        if (d == 0) if8.i_rx_serial = v;
        else        if217.i_rx_serial = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Called on a negedge; returns on a negedge after the stop bit
    task automatic send(input int d, input logic [7:0] b, input int bitlen, input int stoplen,
                        input bit stopval, input int rst_bit, output int t0);
        drive(d, 1'b0);
        t0 = cyc + 1;
        wait_cyc(bitlen);
        for (int k = 0; k < 8; k++) begin
            drive(d, b[k]);
            if (k == rst_bit) begin
                wait_cyc(2);
                i_rst = 1'b1;
                wait_cyc(1);
                check("rst_mid_byte", 32'(if8.o_rx_byte),        32'h00);
                check("rst_mid_dv",   32'(if8.o_rx_dv),          32'h0);
                check("rst_mid_err",  32'(if8.o_rx_framing_err), 32'h0);
                check("rst_mid_act",  32'(if8.o_rx_active),      32'h0);
                i_rst = 1'b0;
                wait_cyc(bitlen - 3);
            end else begin
                wait_cyc(bitlen);
            end
        end
        drive(d, stopval);
        wait_cyc(stoplen);
    endtask

    initial begin
        int t0, dv0, er0, ac0;
        logic [7:0] b;
        int bl;
        bit sv;

        if8.i_rx_serial   = 1'b1;
        if217.i_rx_serial = 1'b1;
        i_rst = 1'b1;
        wait_cyc(3);
        check("reset_byte8",   32'(if8.o_rx_byte),          32'h00);
        check("reset_dv8",     32'(if8.o_rx_dv),            32'h0);
        check("reset_err8",    32'(if8.o_rx_framing_err),   32'h0);
        check("reset_act8",    32'(if8.o_rx_active),        32'h0);
        check("reset_byte217", 32'(if217.o_rx_byte),        32'h00);
        check("reset_act217",  32'(if217.o_rx_active),      32'h0);
        i_rst = 1'b0;
        wait_cyc(5);

        // Ideal 0xA5 frame: dv in the cycle after edge t0+78
        dv0 = dv_cnt[0]; er0 = err_cnt[0];
        send(0, 8'hA5, 8, 8, 1'b1, -1, t0);
        wait_cyc(20);
        check("a5_dv_count", 32'(dv_cnt[0] - dv0), 32'd1);
        check("a5_dv_time",  32'(last_dv_cyc[0]),  32'(t0 + 78));
        check("a5_byte",     32'(if8.o_rx_byte),   32'hA5);
        check("a5_model",    32'(e_byte[0]),       32'hA5);
        check("a5_no_err",   32'(err_cnt[0] - er0), 32'd0);

        // Back-to-back 0x00, 0xFF with a 7-cycle stop bit
        dv0 = dv_cnt[0]; er0 = err_cnt[0];
        send(0, 8'h00, 8, 7, 1'b1, -1, t0);
        check("b2b_first_byte", 32'(if8.o_rx_byte), 32'h00);
        send(0, 8'hFF, 8, 7, 1'b1, -1, t0);
        wait_cyc(20);
        check("b2b_dv_count", 32'(dv_cnt[0] - dv0),  32'd2);
        check("b2b_byte",     32'(if8.o_rx_byte),    32'hFF);
        check("b2b_no_err",   32'(err_cnt[0] - er0), 32'd0);

        // Two-cycle glitch: active for H+1 = 4 cycles, nothing reported
        dv0 = dv_cnt[0]; er0 = err_cnt[0]; ac0 = act_cnt[0];
        drive(0, 1'b0);
        wait_cyc(2);
        drive(0, 1'b1);
        wait_cyc(20);
        check("glitch_act_cycles", 32'(act_cnt[0] - ac0), 32'd4);
        check("glitch_no_dv",      32'(dv_cnt[0] - dv0),  32'd0);
        check("glitch_no_err",     32'(err_cnt[0] - er0), 32'd0);

        // Low stop bit followed by a 20-bit break: one error, byte kept
        dv0 = dv_cnt[0]; er0 = err_cnt[0];
        send(0, 8'h3C, 8, 160, 1'b0, -1, t0);
        drive(0, 1'b1);
        wait_cyc(16);
        check("break_err_count", 32'(err_cnt[0] - er0), 32'd1);
        check("break_no_dv",     32'(dv_cnt[0] - dv0),  32'd0);
        check("break_byte_kept", 32'(if8.o_rx_byte),    32'hFF);
        send(0, 8'h3C, 8, 8, 1'b1, -1, t0);
        wait_cyc(10);
        check("after_break_byte", 32'(if8.o_rx_byte),   32'h3C);
        check("after_break_dv",   32'(dv_cnt[0] - dv0), 32'd1);

        // Reset during data bit 4 aborts the frame silently
        dv0 = dv_cnt[0]; er0 = err_cnt[0];
        send(0, 8'hF3, 8, 8, 1'b1, 4, t0);
        wait_cyc(20);
        check("rst_frame_no_dv",  32'(dv_cnt[0] - dv0),  32'd0);
        check("rst_frame_no_err", 32'(err_cnt[0] - er0), 32'd0);
        send(0, 8'h81, 8, 8, 1'b1, -1, t0);
        wait_cyc(10);
        check("post_rst_byte", 32'(if8.o_rx_byte),   32'h81);
        check("post_rst_dv",   32'(dv_cnt[0] - dv0), 32'd1);

        // Randomised frames, bit-period jitter, bad stop bits and glitches
        for (int i = 0; i < 25; i++) begin
            b  = 8'($urandom);
            bl = $urandom_range(7, 9);
            sv = ($urandom_range(0, 9) != 0);
            send(0, b, bl, bl, sv, -1, t0);
            if (!sv) begin
                wait_cyc($urandom_range(0, 30));
                drive(0, 1'b1);
            end
            if ($urandom_range(0, 3) == 0) begin
                drive(0, 1'b0);
                wait_cyc($urandom_range(1, 6));
                drive(0, 1'b1);
            end
            wait_cyc($urandom_range(0, 12) + 20);
        end

        // 217 cycles/bit with +3 % and -3 % bit periods
        dv0 = dv_cnt[1]; er0 = err_cnt[1];
        send(1, 8'h5A, 223, 223, 1'b1, -1, t0);
        wait_cyc(50);
        check("slow_5A_byte", 32'(if217.o_rx_byte), 32'h5A);
        send(1, 8'hC3, 211, 211, 1'b1, -1, t0);
        wait_cyc(50);
        check("fast_C3_byte", 32'(if217.o_rx_byte), 32'hC3);
        send(1, 8'h5A, 211, 211, 1'b1, -1, t0);
        wait_cyc(50);
        check("fast_5A_byte", 32'(if217.o_rx_byte),  32'h5A);
        check("skew_dv",      32'(dv_cnt[1] - dv0),  32'd3);
        check("skew_no_err",  32'(err_cnt[1] - er0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            b  = 8'($urandom);
            bl = $urandom_range(211, 223);
            send(1, b, bl, bl, 1'b1, -1, t0);
            wait_cyc($urandom_range(0, 40) + 20);
            check("rand217_byte", 32'(if217.o_rx_byte), 32'(b));
        end

        wait_cyc(20);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
